// File: rtl/currctrl_debug_capture.sv
`default_nettype none
// ============================================================================
// Module   : currctrl_debug_capture
// Purpose  : Trigger-based capture engine that drives port 2 of the current-
//            control debug RAM. Decimated 32-bit control-loop samples are
//            streamed into the RAM as a circular buffer. The buffer freezes a
//            programmable number of samples after a trigger, which leaves a
//            record of the samples before and after the trigger.
// Ports    : clk, reset_n (async, active-low)
//            arm / abort            - capture control pulses
//            trig                   - trigger qualifier (accepted samples only)
//            decim, post_count      - capture setup, latched on arm
//            sample_valid/_data     - incoming sample stream
//            ram_*                  - RAM port-2 master (write-only)
//            busy, done, trig_addr,
//            wrapped                - status for the host read-out
// Revision : 1.0 - initial release
// ============================================================================
module currctrl_debug_capture #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int PRE_MIN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_armed = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_post  = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_pre_min  = ADDR_W'(PRE_MIN);
  localparam logic [ADDR_W-1:0] c_pre_last = ADDR_W'(PRE_MIN - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [7:0]        r_decim_l;
  logic [7:0]        r_decim_cnt;
  logic [ADDR_W-1:0] r_post_count_l;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] w_post_cnt_inc;
  logic              r_wrapped;
  logic              r_ram_write;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_writedata;
  logic              w_active;
  logic              w_sample_en;
  logic              w_accept;
  logic              w_trig_hit;

  // abort and arm both take precedence over any sample on the same cycle
  assign w_active       = (r_state == c_st_armed) || (r_state == c_st_wait) ||
                          (r_state == c_st_post);
  assign w_sample_en    = w_active && sample_valid && !abort && !arm;
  assign w_accept       = w_sample_en && (r_decim_cnt == r_decim_l);
  assign w_trig_hit     = w_accept && (r_state == c_st_wait) && trig;
  assign w_post_cnt_inc = r_post_cnt + c_one;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Transitions are taken on the accepting cycle so the very
  // next sample already sees the new state (no dead sample between phases).
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = c_st_idle;
    end else if (arm) begin
      w_next_state = c_st_armed;
    end else begin
      case (r_state)
        c_st_armed: begin
          if (w_accept && (r_pre_cnt >= c_pre_last)) begin
            w_next_state = c_st_wait;
          end
        end
        c_st_wait: begin
          if (w_trig_hit) begin
            w_next_state = (r_post_count_l == '0) ? c_st_done : c_st_post;
          end
        end
        c_st_post: begin
          if (w_accept && (w_post_cnt_inc == r_post_count_l)) begin
            w_next_state = c_st_done;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_st_armed,
      c_st_wait,
      c_st_post: busy = 1'b1;
      c_st_done: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, pointers and the registered RAM write port.
  // An accepted sample is registered into the RAM port on the following edge,
  // so a write already on the bus always completes regardless of abort/arm.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_decim_l       <= '0;
      r_decim_cnt     <= '0;
      r_post_count_l  <= '0;
      r_wr_ptr        <= '0;
      r_pre_cnt       <= '0;
      r_post_cnt      <= '0;
      r_trig_addr     <= '0;
      r_wrapped       <= 1'b0;
      r_ram_write     <= 1'b0;
      r_ram_address   <= '0;
      r_ram_writedata <= '0;
    end else begin
      r_ram_write <= 1'b0;
      if (abort) begin
        // leave pointers and RAM contents untouched for inspection
      end else if (arm) begin
        r_decim_l      <= decim;
        r_post_count_l <= post_count;
        r_decim_cnt    <= '0;
        r_wr_ptr       <= '0;
        r_pre_cnt      <= '0;
        r_post_cnt     <= '0;
        r_wrapped      <= 1'b0;
      end else if (w_sample_en) begin
        if (w_accept) begin
          r_decim_cnt     <= '0;
          r_ram_write     <= 1'b1;
          r_ram_address   <= r_wr_ptr;
          r_ram_writedata <= sample_data;
          r_wr_ptr        <= r_wr_ptr + c_one;
          if (&r_wr_ptr) begin
            r_wrapped <= 1'b1;
          end
          case (r_state)
            c_st_armed: begin
              if (r_pre_cnt != c_pre_min) begin
                r_pre_cnt <= r_pre_cnt + c_one;
              end
            end
            c_st_wait: begin
              if (trig) begin
                r_trig_addr <= r_wr_ptr;
              end
            end
            c_st_post: begin
              r_post_cnt <= w_post_cnt_inc;
            end
            default: begin
              r_post_cnt <= r_post_cnt;
            end
          endcase
        end else begin
          r_decim_cnt <= r_decim_cnt + 8'd1;
        end
      end
    end
  end

  assign ram_address    = r_ram_address;
  assign ram_chipselect = r_ram_write;
  assign ram_write      = r_ram_write;
  assign ram_byteenable = 4'hF;
  assign ram_writedata  = r_ram_writedata;
  assign ram_clken      = 1'b1;
  assign trig_addr      = r_trig_addr;
  assign wrapped        = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_currctrl_debug_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_currctrl_debug_capture
// Purpose  : Self-checking bench for currctrl_debug_capture. A behavioural
//            model tracks capture progress as counts of valid and accepted
//            samples since arm and derives addresses, trigger position and
//            completion arithmetically; DUT outputs are compared each cycle.
//            Directed scenarios are pinned with literal expectations, then a
//            randomized phase runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_currctrl_debug_capture;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int PRE_MIN = 16;
  localparam int DEPTH   = 512;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              arm, abort, trig, sample_valid;
  logic [7:0]        decim;
  logic [ADDR_W-1:0] post_count;
  logic [DATA_W-1:0] sample_data;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write;
  logic [3:0]        ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken, busy, done, wrapped;
  logic [ADDR_W-1:0] trig_addr;

  always #5 clk = ~clk;

  currctrl_debug_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PRE_MIN(PRE_MIN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .abort         (abort),
    .trig          (trig),
    .decim         (decim),
    .post_count    (post_count),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .ram_address   (ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write     (ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_writedata (ram_writedata),
    .ram_clken     (ram_clken),
    .busy          (busy),
    .done          (done),
    .trig_addr     (trig_addr),
    .wrapped       (wrapped)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: progress measured as sample counts since arm
  bit m_cap, m_done, m_trig_seen;
  int m_k, m_vcnt, m_trig_k, m_decim, m_post;

  // expected outputs for the cycle following the last model step
  logic              e_write, e_busy, e_done, e_wrapped;
  logic [ADDR_W-1:0] e_addr, e_trig_addr;
  logic [DATA_W-1:0] e_data;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t obs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_trig_seen = 0;
    m_k = 0; m_vcnt = 0; m_trig_k = 0; m_decim = 0; m_post = 0;
    e_write = 0; e_busy = 0; e_done = 0; e_wrapped = 0;
    e_addr = '0; e_trig_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input logic a_arm, input logic a_abort, input logic a_trig,
                            input logic a_valid, input logic [DATA_W-1:0] a_data,
                            input logic [7:0] a_decim, input logic [ADDR_W-1:0] a_post);
    e_write = 1'b0;
    if (a_abort) begin
      m_cap  = 0;
      m_done = 0;
    end else if (a_arm) begin
      m_cap = 1; m_done = 0; m_trig_seen = 0;
      m_k = 0; m_vcnt = 0;
      m_decim = int'(a_decim);
      m_post  = int'(a_post);
    end else if (m_cap && a_valid) begin
      if ((m_vcnt % (m_decim + 1)) == m_decim) begin
        e_write = 1'b1;
        e_addr  = ADDR_W'(m_k % DEPTH);
        e_data  = a_data;
        if (!m_trig_seen && m_k >= PRE_MIN && a_trig) begin
          m_trig_seen = 1;
          m_trig_k    = m_k;
          e_trig_addr = ADDR_W'(m_k % DEPTH);
        end
        m_k++;
        if (m_trig_seen && m_k == m_trig_k + m_post + 1) begin
          m_cap  = 0;
          m_done = 1;
        end
      end
      m_vcnt++;
    end
    e_busy    = m_cap;
    e_done    = m_done;
    e_wrapped = (m_k >= DEPTH);
  endtask

  task automatic compare();
    chk("ram_write",      64'(ram_write),      64'(e_write));
    chk("ram_chipselect", 64'(ram_chipselect), 64'(e_write));
    chk("ram_address",    64'(ram_address),    64'(e_addr));
    chk("ram_writedata",  64'(ram_writedata),  64'(e_data));
    chk("busy",           64'(busy),           64'(e_busy));
    chk("done",           64'(done),           64'(e_done));
    chk("trig_addr",      64'(trig_addr),      64'(e_trig_addr));
    chk("wrapped",        64'(wrapped),        64'(e_wrapped));
    chk("ram_byteenable", 64'(ram_byteenable), 64'(4'hF));
    chk("ram_clken",      64'(ram_clken),      64'(1'b1));
    if (ram_write === 1'b1) obs.push_back('{ram_address, ram_writedata});
  endtask

  task automatic cycle(input logic a_arm, input logic a_abort, input logic a_trig,
                       input logic a_valid, input logic [DATA_W-1:0] a_data,
                       input logic [7:0] a_decim, input logic [ADDR_W-1:0] a_post);
    @(negedge clk);
    compare();
    reset_n      = 1'b1;
    arm          = a_arm;
    abort        = a_abort;
    trig         = a_trig;
    sample_valid = a_valid;
    sample_data  = a_data;
    decim        = a_decim;
    post_count   = a_post;
    model_step(a_arm, a_abort, a_trig, a_valid, a_data, a_decim, a_post);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare();
    reset_n = 1'b0;
    arm = 0; abort = 0; trig = 0; sample_valid = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              r_arm, r_abort, r_trig, r_valid;
    logic [7:0]        r_decim;
    logic [ADDR_W-1:0] r_post;
    int                r;

    reset_n = 1'b0; arm = 0; abort = 0; trig = 0; sample_valid = 0;
    sample_data = '0; decim = '0; post_count = '0;
    model_reset();
    do_reset();
    idle(3);

    // basic capture: decim 0, post 4, trigger on sample 20
    obs.delete();
    cycle(1, 0, 0, 0, '0, 8'd0, 9'd4);
    for (int i = 0; i < 28; i++) cycle(0, 0, (i == 20), 1, 32'(i), 8'd0, 9'd4);
    idle(2);
    chk("t2_done",       64'(done),      64'(1));
    chk("t2_trig_addr",  64'(trig_addr), 64'(20));
    chk("t2_wrapped",    64'(wrapped),   64'(0));
    chk("t2_nwrites",    64'(obs.size()), 64'(25));
    chk("t2_last_addr",  64'(obs[24].a), 64'(24));
    chk("t2_last_data",  64'(obs[24].d), 64'(24));

    // reset in the middle of the post-trigger phase
    cycle(1, 0, 0, 0, '0, 8'd0, 9'd100);
    for (int i = 0; i < 30; i++) cycle(0, 0, (i == 20), 1, 32'(i), 8'd0, 9'd100);
    do_reset();
    obs.delete();
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 32'(i), 8'd0, 9'd0);
    chk("t1_no_writes",  64'(obs.size()), 64'(0));
    chk("t1_trig_addr",  64'(trig_addr),  64'(0));
    chk("t1_busy",       64'(busy),       64'(0));

    // decimation by 4
    obs.delete();
    cycle(1, 0, 0, 0, '0, 8'd3, 9'd4);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 32'(i), 8'd3, 9'd4);
    cycle(0, 1, 0, 0, '0, 8'd3, 9'd4);
    idle(1);
    chk("t3_nwrites",    64'(obs.size()), 64'(5));
    chk("t3_w0",         64'({obs[0].a, obs[0].d}), 64'({9'd0, 32'd3}));
    chk("t3_w1",         64'({obs[1].a, obs[1].d}), 64'({9'd1, 32'd7}));
    chk("t3_w2",         64'({obs[2].a, obs[2].d}), 64'({9'd2, 32'd11}));

    // trigger held high from arm
    obs.delete();
    cycle(1, 0, 1, 0, '0, 8'd0, 9'd3);
    for (int i = 0; i < 25; i++) cycle(0, 0, 1, 1, 32'(i), 8'd0, 9'd3);
    idle(2);
    chk("t4_trig_addr",  64'(trig_addr),  64'(16));
    chk("t4_done",       64'(done),       64'(1));
    chk("t4_nwrites",    64'(obs.size()), 64'(20));

    // long pre-trigger history with wrap, post 0
    obs.delete();
    cycle(1, 0, 0, 0, '0, 8'd0, 9'd0);
    for (int i = 0; i < 600; i++) cycle(0, 0, 0, 1, 32'(i), 8'd0, 9'd0);
    cycle(0, 0, 1, 1, 32'd600, 8'd0, 9'd0);
    for (int i = 601; i < 605; i++) cycle(0, 0, 1, 1, 32'(i), 8'd0, 9'd0);
    idle(1);
    chk("t5_trig_addr",  64'(trig_addr), 64'(88));
    chk("t5_wrapped",    64'(wrapped),   64'(1));
    chk("t5_done",       64'(done),      64'(1));
    chk("t5_last",       64'({obs[obs.size()-1].a, obs[obs.size()-1].d}), 64'({9'd88, 32'd600}));

    // abort + arm together during post, then arm with trig
    cycle(1, 0, 0, 0, '0, 8'd0, 9'd100);
    for (int i = 0; i < 30; i++) cycle(0, 0, (i == 20), 1, 32'(i), 8'd0, 9'd100);
    cycle(1, 1, 0, 1, 32'd99, 8'd0, 9'd100);
    idle(2);
    chk("t6_busy",       64'(busy), 64'(0));
    chk("t6_done",       64'(done), 64'(0));
    cycle(1, 0, 1, 1, 32'd0, 8'd0, 9'd5);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 32'(i), 8'd0, 9'd5);
    idle(1);
    chk("t6_busy_armed", 64'(busy),      64'(1));
    chk("t6_trig_kept",  64'(trig_addr), 64'(20));
    cycle(0, 1, 0, 0, '0, 8'd0, 9'd5);

    // randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      r       = $urandom_range(0, 999);
      r_arm   = (r < 4) || (!m_cap && r < 40);
      r_abort = (r >= 996);
      r_valid = ($urandom_range(0, 9) < 7);
      r_trig  = ($urandom_range(0, 19) == 0);
      r_decim = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 3));
      r_post  = ($urandom_range(0, 7) == 0) ? 9'd511 : 9'($urandom_range(0, 30));
      cycle(r_arm, r_abort, r_trig, r_valid, $urandom, r_decim, r_post);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
